// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meas_pkg;

   localparam int CPM_CNT_W_DEF   = 16;
   localparam int CPM_TIMEOUT_DEF = 65535;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } cpm_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a delay flop
// that provides a single-cycle rising-edge pulse.
module sync_edge_det (
   input  logic clkin,
   input  logic reset,
   input  logic d,
   output logic q_sync,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_dly;

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_dly <= 1'b0;
      end else begin
         r_s1  <= d;
         r_s2  <= r_s1;
         r_dly <= r_s2;
      end
   end

   assign q_sync = r_s2;
   assign rise   = r_s2 & ~r_dly;

endmodule

// File: rtl/clk_period_meter.sv
// Measures rising-to-rising period (and optionally high time) of a slow async
// signal in clkin cycles. Define CPM_HIGH_TIME_EN to build the high-time counter.
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W   = CPM_CNT_W_DEF,
   parameter int TIMEOUT = CPM_TIMEOUT_DEF
) (
   input  logic             clkin,
   input  logic             reset,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             timeout,
   output logic [7:0]       meas_cnt
);

   localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

   cpm_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic             r_valid;
   logic             r_timeout;
   logic [7:0]       r_meas;

   logic             w_sync;
   logic             w_rise;
   logic [CNT_W-1:0] w_cnt_inc;

   sync_edge_det u_sync (
      .clkin  (clkin),
      .reset  (reset),
      .d      (sig_in),
      .q_sync (w_sync),
      .rise   (w_rise)
   );

   assign w_cnt_inc = r_cnt + LP_ONE;

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_period  <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_meas    <= 8'd0;
      end else begin
         r_valid <= 1'b0;
         if (!en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt   <= '0;
                  r_state <= ARM;
               end
               ARM: begin
                  r_cnt <= '0;
                  if (w_rise) r_state <= MEASURE;
               end
               MEASURE: begin
                  // The rise is checked first so an edge landing on the
                  // timeout cycle still yields a measurement.
                  if (w_rise) begin
                     r_period  <= w_cnt_inc;
                     r_valid   <= 1'b1;
                     r_cnt     <= '0;
                     r_timeout <= 1'b0;
                     r_meas    <= r_meas + 8'd1;
                  end else if (r_cnt == LP_TIMEOUT) begin
                     r_timeout <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= ARM;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

`ifdef CPM_HIGH_TIME_EN
   logic [CNT_W-1:0] r_hcnt;
   logic [CNT_W-1:0] r_high;

   always_ff @(posedge clkin) begin
      if (reset) begin
         r_hcnt <= '0;
         r_high <= '0;
      end else if (!en || r_state != MEASURE) begin
         r_hcnt <= '0;
      end else if (w_rise) begin
         // The rise cycle itself is high and closes the period.
         r_high <= r_hcnt + LP_ONE;
         r_hcnt <= '0;
      end else if (r_cnt == LP_TIMEOUT) begin
         r_hcnt <= '0;
      end else if (w_sync) begin
         r_hcnt <= r_hcnt + LP_ONE;
      end
   end

   assign high_time = r_high;
`else
   logic w_unused_sync;
   assign w_unused_sync = w_sync;
   assign high_time     = '0;
`endif

   assign period       = r_period;
   assign period_valid = r_valid;
   assign timeout      = r_timeout;
   assign meas_cnt     = r_meas;

endmodule
